debug_frame_serializer: RTL and testbench
=========================================

// Module: debug_frame_serializer
// PURPOSE
//  Multi-channel debug latch serializer. It sits between the MIPS debug taps and the debug
//  interface (UART framer). When a request select matches one of N_CHANNELS consecutive IDs,
//  it snapshots that channel's word and streams it as NB_LATCH-bit frames, MSB first, over a
//  valid/ready handshake.
// PARAMETERS
//  NB_LATCH        32         frame width, bits per beat
//  NB_INPUT_SIZE   32         width of each channel's data word
//  N_CHANNELS      4          number of debug channels, >=1
//  NB_ID           6          request select width
//  BASE_ID         6'b000000  ID of channel 0; channel k answers to BASE_ID+k
// PORTS
//  i_clock              in   1                        clock, rising edge
//  i_reset              in   1                        reset, asynchronous, active-high
//  i_request_select     in   NB_ID                    requested controller ID
//  i_data_from_mips     in   N_CHANNELS*NB_INPUT_SIZE channel k at [(k+1)*NB_INPUT_SIZE-1 -: NB_INPUT_SIZE]
//  i_frame_ready        in   1                        interface accepts o_frame_to_interface
//  o_frame_to_interface out  NB_LATCH                 current frame; zero when o_frame_valid=0
//  o_frame_valid        out  1                        frame valid
//  o_frame_last         out  1                        final beat of the transfer, qualified by valid
//  o_writing            out  1                        high for the whole transfer (IDLE exit to done)
//  o_channel            out  clog2(N_CHANNELS) (min 1) channel being sent
// BEHAVIOUR
//  - Derived values: PAD = (-NB_INPUT_SIZE) mod NB_LATCH; BEATS = ceil(NB_INPUT_SIZE/NB_LATCH).
//    Beat counter width is clog2(BEATS+2).
//  - Match: i_request_select in [BASE_ID, BASE_ID+N_CHANNELS-1]. The index is a modulo-2^NB_ID
//    subtraction; BASE_ID+N_CHANNELS must not exceed 2^NB_ID.
//  - Trigger: match & (~match_q | sel != sel_q). match_q and sel_q are registered every cycle
//    in all states.
//    - A held ID does not retrigger.
//    - A direct switch from one matching ID to another does retrigger.
//  - FSM: IDLE, SEND.
//    - IDLE: on trigger, snapshot {channel word, PAD zeros} into shadow, latch o_channel,
//      beat=0, go to SEND. o_frame_valid rises on the next cycle (1-cycle latency).
//    - SEND: o_frame_to_interface = shadow[top - beat*NB_LATCH -: NB_LATCH].
//      On valid&ready: if beat==BEATS-1, go to IDLE; else beat+1.
//    - Valid holds with stable data while ready=0 (no drop, no change).
//  - Triggers seen in SEND are ignored, not queued. After the return to IDLE, a new trigger
//    needs a fresh edge or ID change.
//  - Input data changing during SEND has no effect (snapshot only).
//  - o_frame_last = valid & (beat==BEATS-1). o_writing = (state==SEND).
//  - Reset (async, any time, including mid-transfer):
//    - state IDLE; beat, shadow, match_q, sel_q, o_channel cleared.
//    - All outputs 0; the aborted transfer never shows last.
//  - Trigger and completion in the same cycle: completion wins and the trigger is dropped.
// CONFIGURATION
//  DEBUG_SERIALIZER_HEADER_EN
//   defined:
//    - One header beat is sent before the data beats. It carries the responding ID in bits
//      [NB_ID+7:8] and BEATS[7:0] in bits [7:0], other bits zero.
//    - o_frame_last stays on the final data beat. The header needs NB_LATCH >= NB_ID+8.
//   undefined: no header; the first beat is the data MSBs.
// TESTING
//  1 Defaults, ch0=32'hDEADBEEF, sel 6'h3F->6'h00, ready=1 -> 1 cycle later one frame
//    32'hDEADBEEF, valid=last=1 for 1 cycle, o_channel=0.
//  2 NB_INPUT_SIZE=40, ch2=40'h12_3456_789A, sel->BASE+2, ready=1 -> frames 32'h12345678 then
//    32'h9A000000, last on 2nd only.
//  3 Test 2 with ready low for 3 cycles on beat 0 -> 32'h12345678 held valid and stable for
//    4 cycles; ch2 changed meanwhile is not sent.
//  4 sel held at BASE+1 for 20 cycles -> exactly one transfer; switch to BASE+3 -> second
//    transfer with o_channel=3.
//  5 i_reset pulsed mid-beat 0 of test 2 (async, between edges) -> valid, last, writing drop
//    immediately; no further frames until a new trigger.
//  6 HEADER_EN, test 2 with BASE_ID=6'h10 -> frames 32'h00001202, 32'h12345678, 32'h9A000000;
//    last on 3rd.

Source files
------------

// File: rtl/debug_frame_serializer.sv
// rtl/debug_frame_serializer.sv - snapshots a matched debug channel and streams it as MSB-first frames
// Optional header beat: define DEBUG_SERIALIZER_HEADER_EN.
module debug_frame_serializer #(
  parameter int               NB_LATCH      = 32,
  parameter int               NB_INPUT_SIZE = 32,
  parameter int               N_CHANNELS    = 4,
  parameter int               NB_ID         = 6,
  parameter logic [NB_ID-1:0] BASE_ID       = '0,
  localparam int              CH_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [NB_ID-1:0]                    i_request_select,
  input  logic [N_CHANNELS*NB_INPUT_SIZE-1:0] i_data_from_mips,
  input  logic                                i_frame_ready,
  output logic [NB_LATCH-1:0]                 o_frame_to_interface,
  output logic                                o_frame_valid,
  output logic                                o_frame_last,
  output logic                                o_writing,
  output logic [CH_W-1:0]                     o_channel
);

  localparam int BEATS = (NB_INPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
`ifdef DEBUG_SERIALIZER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = BEATS + HDR;
  localparam int SW    = TOTAL * NB_LATCH;
  localparam int BW    = $clog2(BEATS + 2);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(TOTAL - 1);
  localparam logic [NB_ID:0] N_CH_EXT  = (NB_ID + 1)'(N_CHANNELS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [SW-1:0]      shadow_q, shadow_d;
  logic               match_q, match_d;
  logic [NB_ID-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]    channel_q, channel_d;

  logic [NB_ID-1:0]         idx;
  logic                     match;
  logic                     trigger;
  logic                     handshake;
  logic [NB_INPUT_SIZE-1:0] word;

  // Modulo subtraction: IDs below BASE_ID wrap high and fail the range test.
  always_comb begin
    idx     = i_request_select - BASE_ID;
    match   = ({1'b0, idx} < N_CH_EXT);
    trigger = match & (~match_q | (i_request_select != sel_q));
    word    = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (idx == NB_ID'(k)) word = i_data_from_mips[k*NB_INPUT_SIZE +: NB_INPUT_SIZE];
    end
  end

  assign o_writing            = (state_q == SEND);
  assign o_frame_valid        = o_writing;
  assign o_frame_to_interface = o_writing ? shadow_q[SW-1 -: NB_LATCH] : '0;
  assign o_frame_last         = o_frame_valid && (beat_q == LAST_BEAT);
  assign o_channel            = channel_q;
  assign handshake            = o_frame_valid & i_frame_ready;

  always_comb begin
`ifdef DEBUG_SERIALIZER_HEADER_EN
    logic [NB_LATCH-1:0] header;
    header            = '0;
    header[NB_ID+7:8] = i_request_select;
    header[7:0]       = 8'(BEATS);
`endif
    state_d   = state_q;
    beat_d    = beat_q;
    shadow_d  = shadow_q;
    channel_d = channel_q;
    match_d   = match;
    sel_d     = i_request_select;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          shadow_d = '0;
`ifdef DEBUG_SERIALIZER_HEADER_EN
          shadow_d[SW-1 -: NB_LATCH] = header;
`endif
          shadow_d[BEATS*NB_LATCH-1 -: NB_INPUT_SIZE] = word;
          channel_d = idx[CH_W-1:0];
          beat_d    = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        // Triggers here are deliberately dropped; the top beat of shadow is always on the bus.
        if (handshake) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            beat_d   = beat_q + BW'(1);
            shadow_d = shadow_q << NB_LATCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      shadow_q  <= '0;
      match_q   <= 1'b0;
      sel_q     <= '0;
      channel_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shadow_q  <= shadow_d;
      match_q   <= match_d;
      sel_q     <= sel_d;
      channel_q <= channel_d;
    end
  end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// tb/tb_debug_frame_serializer.sv - directed self-checking bench for debug_frame_serializer
module tb_debug_frame_serializer;

`ifdef DEBUG_SERIALIZER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   sel_a, sel_b;
  logic [127:0] data_a;
  logic [159:0] data_b;
  logic         rdy_a, rdy_b;
  logic [31:0]  frame_a, frame_b;
  logic         valid_a, valid_b, last_a, last_b, wr_a, wr_b;
  logic [1:0]   ch_a, ch_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_b;
  logic [31:0] exp_b [3];

  always #5 clk = ~clk;

  debug_frame_serializer u_a (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel_a), .i_data_from_mips(data_a),
    .i_frame_ready(rdy_a), .o_frame_to_interface(frame_a), .o_frame_valid(valid_a),
    .o_frame_last(last_a), .o_writing(wr_a), .o_channel(ch_a)
  );

  debug_frame_serializer #(.NB_INPUT_SIZE(40), .BASE_ID(6'h10)) u_b (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel_b), .i_data_from_mips(data_b),
    .i_frame_ready(rdy_b), .o_frame_to_interface(frame_b), .o_frame_valid(valid_b),
    .o_frame_last(last_b), .o_writing(wr_b), .o_channel(ch_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks a full ready=1 transfer on u_b against exp_b[0..n_b-1].
  task automatic run_b(input string tag);
    for (int i = 0; i < n_b; i++) begin
      chk({tag, "_valid"}, valid_b, 1'b1);
      chk({tag, "_frame"}, frame_b, exp_b[i]);
      chk({tag, "_last"}, last_b, (i == n_b - 1));
      step();
    end
    chk({tag, "_idle_valid"}, valid_b, 1'b0);
    chk({tag, "_idle_writing"}, wr_b, 1'b0);
  endtask

  initial begin
    int cnt;
    int lasts;
    rst    = 1'b1;
    sel_a  = 6'h3F;
    data_a = '0;
    data_a[31:0] = 32'hDEADBEEF;
    data_a[95:64] = 32'h5555AAAA;
    rdy_a  = 1'b1;
    sel_b  = 6'h00;
    data_b = '0;
    data_b[119:80] = 40'h12_3456_789A;
    rdy_b  = 1'b1;
    if (HDR == 1) begin
      n_b = 3;
      exp_b[0] = 32'h00001202; exp_b[1] = 32'h12345678; exp_b[2] = 32'h9A000000;
    end else begin
      n_b = 2;
      exp_b[0] = 32'h12345678; exp_b[1] = 32'h9A000000; exp_b[2] = 32'h0;
    end

    #2;
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_frame_a", frame_a, 32'h0);
    chk("rst_last_a", last_a, 1'b0);
    chk("rst_writing_a", wr_a, 1'b0);
    chk("rst_channel_a", ch_a, 2'd0);
    chk("rst_valid_b", valid_b, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("nomatch_3f", valid_a, 1'b0);

    // Test 1: 3F -> 00 on default instance
    sel_a = 6'h00;
    step();
    if (HDR == 1) begin
      chk("t1_hdr", frame_a, 32'h00000001);
      chk("t1_hdr_last", last_a, 1'b0);
      step();
    end
    chk("t1_valid", valid_a, 1'b1);
    chk("t1_frame", frame_a, 32'hDEADBEEF);
    chk("t1_last", last_a, 1'b1);
    chk("t1_writing", wr_a, 1'b1);
    chk("t1_channel", ch_a, 2'd0);
    step();
    chk("t1_done_valid", valid_a, 1'b0);
    chk("t1_done_writing", wr_a, 1'b0);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (valid_a) cnt++;
    end
    chk("t1_held_no_retrigger", cnt, 0);

    // Trigger arriving on the completion edge is dropped
    sel_a = 6'h02;
    step();
    chk("drop_start_channel", ch_a, 2'd2);
    sel_a = 6'h01;
    step();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (valid_a) cnt++;
      step();
    end
    chk("drop_trigger_beats", cnt, HDR);

    // Test 2: 40-bit word on channel 2 of u_b
    sel_b = 6'h12;
    step();
    chk("t2_channel", ch_b, 2'd2);
    run_b("t2");

    // Test 3: backpressure on beat 0, data changed during send
    sel_b = 6'h00;
    step();
    sel_b = 6'h12;
    rdy_b = 1'b0;
    step();
    for (int j = 0; j < 4; j++) begin
      chk("t3_hold_valid", valid_b, 1'b1);
      chk("t3_hold_frame", frame_b, exp_b[0]);
      chk("t3_hold_last", last_b, 1'b0);
      if (j == 0) data_b[119:80] = 40'hFF_FFFF_FFFF;
      if (j < 3) step();
    end
    rdy_b = 1'b1;
    step();
    for (int i = 1; i < n_b; i++) begin
      chk("t3_frame", frame_b, exp_b[i]);
      chk("t3_last", last_b, (i == n_b - 1));
      step();
    end
    chk("t3_done_valid", valid_b, 1'b0);
    data_b[119:80] = 40'h12_3456_789A;

    // Test 4: held ID sends once; switching ID retriggers
    sel_b = 6'h00;
    data_b[79:40]   = 40'h01_0203_0405;
    data_b[159:120] = 40'hAB_CDEF_0123;
    step();
    sel_b = 6'h11;
    cnt = 0;
    lasts = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (valid_b && rdy_b) cnt++;
      if (last_b) lasts++;
    end
    chk("t4_held_beats", cnt, n_b);
    chk("t4_held_lasts", lasts, 1);
    chk("t4_held_channel", ch_b, 2'd1);
    sel_b = 6'h13;
    step();
    chk("t4_sw_valid", valid_b, 1'b1);
    chk("t4_sw_channel", ch_b, 2'd3);
    chk("t4_sw_frame", frame_b, (HDR == 1) ? 32'h00001302 : 32'hABCDEF01);
    lasts = 0;
    for (int c = 0; c < 10; c++) begin
      if (last_b) lasts++;
      step();
    end
    chk("t4_sw_lasts", lasts, 1);

    // Test 5: asynchronous reset in the middle of beat 0
    sel_b = 6'h00;
    step();
    sel_b = 6'h12;
    rdy_b = 1'b0;
    step();
    chk("t5_pre_valid", valid_b, 1'b1);
    #3;
    rst = 1'b1;
    sel_b = 6'h00;
    #1;
    chk("t5_rst_valid", valid_b, 1'b0);
    chk("t5_rst_last", last_b, 1'b0);
    chk("t5_rst_writing", wr_b, 1'b0);
    chk("t5_rst_frame", frame_b, 32'h0);
    chk("t5_rst_channel", ch_b, 2'd0);
    step();
    rst = 1'b0;
    rdy_b = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (valid_b || last_b) cnt++;
    end
    chk("t5_quiet_after_reset", cnt, 0);
    sel_b = 6'h12;
    step();
    run_b("t5_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
